uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single UART byte transmitter among N requesters. It sits in front of the transmitter and drives its DATA/START inputs. It follows the transmitter's level START / BUSY handshake: START is held until BUSY rises, then the arbiter waits for BUSY to fall. A watchdog drops a byte whose transmission never starts or never finishes.

## Interface
- N, 4: number of requesters, 2..8.
- TIMEOUT, 200000: watchdog limit in CLK cycles for each of the START and WAIT phases; counter width $clog2(TIMEOUT+1).
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  N  requester i has a byte.
- REQ_DATA  in  8*N  byte of requester i at [8i+7:8i].
- REQ_LAST  in  N  last byte of requester i's message; used only with UART_ARB_LOCK_EN.
- REQ_READY  out  N  one-hot; the byte is accepted on an edge where VALID[i] and READY[i] are both 1.
- TX_DATA  out  8  to transmitter DATA; registered.
- TX_START  out  1  to transmitter START; registered.
- TX_BUSY  in  1  from transmitter BUSY.
- GRANT_ID  out  $clog2(N)  index of the last accepted requester.
- ERR_TIMEOUT  out  1  one-cycle pulse when the watchdog fires.
- IDLE  out  1  high in state IDLE.

## Operation
- FSM states and transitions:
  - IDLE: go to START on accept.
  - START: go to WAIT when TX_BUSY=1; go to IDLE on timeout.
  - WAIT: go to IDLE when TX_BUSY=0; go to IDLE on timeout.
- Pick logic, in IDLE only:
  - Search VALID starting at pointer `ptr`, wrapping modulo N; the first set bit wins.
  - REQ_READY = one-hot of the winner, combinational from REQ_VALID and `ptr`.
  - REQ_READY is all zeros outside IDLE or when no VALID bit is set.
- On accept of requester w:
  - TX_DATA <= REQ_DATA[w], TX_START <= 1, GRANT_ID <= w.
  - `ptr` <= (w+1) mod N, wrapping N-1 to 0.
- START: TX_START and TX_DATA are held constant until TX_BUSY=1 is sampled. On that edge TX_START <= 0.
- WAIT: TX_START=0. On the edge where TX_BUSY=0 is sampled, go to IDLE.
- Watchdog:
  - Counter is cleared on every state change and increments each cycle in START and WAIT.
  - When it reaches TIMEOUT: TX_START <= 0, ERR_TIMEOUT pulses for 1 cycle, go to IDLE.
  - The byte is dropped, not retried, and `ptr` is unchanged.
- Simultaneous events:
  - TX_BUSY transition and timeout in the same cycle: the TX_BUSY transition wins and ERR_TIMEOUT stays 0.
  - A VALID change during START/WAIT is ignored until IDLE.
- Reset values:
  - TX_START=0, TX_DATA=0x00, GRANT_ID=0, ERR_TIMEOUT=0.
  - REQ_READY=0 until after reset deasserts.
  - State IDLE (IDLE=1), `ptr`=0, watchdog counter=0, lock cleared.
- Reset mid-operation: outputs go to reset values immediately and asynchronously. The transmitter has no reset, so a byte already in flight completes on the line, and the arbiter does not track it.

## Timing
- Accept at edge E0: TX_START=1 and TX_DATA valid after E0.
- TX_BUSY first sampled high at edge E1: TX_START=0 after E1.
- TX_BUSY sampled low at edge E2: IDLE=1 after E2. The next accept can occur at E2+1.
- Minimum spacing between accepts: 3 cycles (with TX_BUSY rising and falling one cycle apart).
- REQ_READY depends combinationally on REQ_VALID. Requesters must not drive VALID combinationally from READY.

## Configuration
- UART_ARB_LOCK_EN defined:
  - Accepting a byte from w with REQ_LAST[w]=0 sets the lock to w.
  - While locked, only w may be picked; the other requesters get REQ_READY=0.
  - Accepting a byte from w with REQ_LAST[w]=1 clears the lock.
  - A timeout or reset clears the lock.
  - `ptr` still updates to w+1, so fairness resumes after the message.
- UART_ARB_LOCK_EN undefined: REQ_LAST is ignored and there is no lock register. Arbitration is strictly per byte.

## Structure
- Package uart_arb_pkg holds:
  - the state enum (IDLE, START, WAIT);
  - UART_BYTE_W=8;
  - the default TIMEOUT constant.
- Sub-module rr_picker (parameter N): inputs VALID and `ptr`, optional lock mask; output is the one-hot grant plus its index. It is purely combinational.
- FSM, watchdog counter and output registers live in uart_tx_arbiter.

## Test plan
- After reset, only VALID[0] with DATA 0x55: READY[0]=1 for 1 cycle. Next cycle TX_START=1 and TX_DATA=0x55, held until TX_BUSY=1, dropping 1 cycle later. IDLE=1 the cycle after TX_BUSY=0. GRANT_ID=0.
- N=4, all VALID held with distinct bytes 0xA0..0xA3: transmitted order is 0xA0, 0xA1, 0xA2, 0xA3, 0xA0, with GRANT_ID 0, 1, 2, 3, 0.
- With `ptr`=3 and only VALID[2]: wrap-around picks 2, and `ptr` becomes 3.
- TIMEOUT=16, TX_BUSY tied 0: ERR_TIMEOUT pulses 16 cycles after TX_START rises. TX_START=0, IDLE=1, and the next accept goes to the same pick order.
- With UART_ARB_LOCK_EN, N=2: requester 1 sends 0x10 (LAST=0) then 0x11 (LAST=1) while VALID[0] is held. Order is 0x10, 0x11, then requester 0's byte. Without the macro, the order is 0x10, requester 0's byte, 0x11.
- RST_N pulsed low during WAIT: TX_START, ERR_TIMEOUT and REQ_READY go to 0 immediately and IDLE=1. After release, `ptr`=0 and requester 0 wins a tie.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
//   arb_state_e          : sequencer states (idle / start handshake / wait busy)
//   UART_BYTE_W          : width of one transmitted byte
//   UART_TIMEOUT_DEFAULT : default watchdog limit in CLK cycles
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam int UART_BYTE_W          = 8;
  localparam int UART_TIMEOUT_DEFAULT = 200000;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   valid     : request vector
//   ptr       : index where the search starts (wraps modulo N)
//   lock_mask : requesters allowed to win (all ones when unlocked)
//   grant     : one-hot winner, zero when nothing eligible
//   grant_idx : index of the winner
//   any       : a winner exists
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  lock_mask,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [N-1:0]  elig;
  logic [IW-1:0] idx;

  assign elig = valid & lock_mask;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!any && elig[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART byte transmitter among N requesters
// using the transmitter's level START/BUSY handshake, with a watchdog that
// drops a byte whose transmission never starts or never finishes.
//   CLK, RST_N            : clock, asynchronous active-low reset
//   REQ_VALID/DATA/LAST   : requester side (LAST only used with message lock)
//   REQ_READY             : one-hot accept, combinational from REQ_VALID
//   TX_DATA, TX_START     : registered drive to the transmitter
//   TX_BUSY               : transmitter busy
//   GRANT_ID              : index of the last accepted requester
//   ERR_TIMEOUT           : one-cycle watchdog pulse
//   IDLE                  : sequencer idle
// Build option: define UART_ARB_LOCK_EN to keep a multi-byte message
// (bytes up to REQ_LAST) on one requester.
//
// state    | meaning
// ST_IDLE  | picking; REQ_READY may be asserted
// ST_START | TX_START held, waiting for TX_BUSY to rise
// ST_WAIT  | waiting for TX_BUSY to fall
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = UART_TIMEOUT_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [N-1:0]           REQ_VALID,
  input  logic [8*N-1:0]         REQ_DATA,
  input  logic [N-1:0]           REQ_LAST,
  output logic [N-1:0]           REQ_READY,
  output logic [UART_BYTE_W-1:0] TX_DATA,
  output logic                   TX_START,
  input  logic                   TX_BUSY,
  output logic [$clog2(N)-1:0]   GRANT_ID,
  output logic                   ERR_TIMEOUT,
  output logic                   IDLE
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic [IW-1:0]          ptr_q, ptr_d;
  logic                   err_q, err_d;

  logic [N-1:0]           lock_mask;
  logic [N-1:0]           pick_grant;
  logic [IW-1:0]          pick_idx;
  logic                   pick_any;
  logic [UART_BYTE_W-1:0] sel_byte;
  logic                   accept;
  logic                   timeout_hit;
  logic                   timeout_fire;

  rr_picker #(.N(N), .IW(IW)) u_picker (
    .valid     (REQ_VALID),
    .ptr       (ptr_q),
    .lock_mask (lock_mask),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < N; i++) begin
      if (pick_grant[i]) sel_byte = REQ_DATA[8*i +: 8];
    end
  end

  // Gated with RST_N so nothing is offered while reset is held.
  assign REQ_READY = (RST_N && state_q == ST_IDLE) ? pick_grant : '0;

  assign accept      = (state_q == ST_IDLE) && pick_any;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
  // A BUSY transition in the same cycle takes priority over the watchdog.
  assign timeout_fire = timeout_hit &&
                        (((state_q == ST_START) && !TX_BUSY) ||
                         ((state_q == ST_WAIT)  &&  TX_BUSY));

`ifdef UART_ARB_LOCK_EN
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_id_q, lock_id_d;

  assign lock_mask = lock_q ? (N'(1) << lock_id_q) : '1;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (timeout_fire) begin
      lock_d = 1'b0;
    end else if (accept) begin
      lock_d    = !REQ_LAST[pick_idx];
      lock_id_d = pick_idx;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^REQ_LAST;
  assign lock_mask   = '1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    tx_data_d  = tx_data_q;
    tx_start_d = tx_start_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_START;
          tx_data_d  = sel_byte;
          tx_start_d = 1'b1;
          grant_d    = pick_idx;
          ptr_d      = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + IW'(1);
        end
      end
      ST_START: begin
        if (TX_BUSY) begin
          state_d    = ST_WAIT;
          tx_start_d = 1'b0;
        end else if (timeout_hit) begin
          state_d    = ST_IDLE;
          tx_start_d = 1'b0;
          err_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT: begin
        if (!TX_BUSY) begin
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      grant_q    <= '0;
      ptr_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      err_q      <= err_d;
    end
  end

  assign TX_DATA     = tx_data_q;
  assign TX_START    = tx_start_q;
  assign GRANT_ID    = grant_q;
  assign ERR_TIMEOUT = err_q;
  assign IDLE        = (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b1;
  logic [N-1:0]   REQ_VALID = '0;
  logic [8*N-1:0] REQ_DATA = '0;
  logic [N-1:0]   REQ_LAST = '0;
  logic [N-1:0]   REQ_READY;
  logic [7:0]     TX_DATA;
  logic           TX_START;
  logic           TX_BUSY = 1'b0;
  logic [1:0]     GRANT_ID;
  logic           ERR_TIMEOUT;
  logic           IDLE;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
    .REQ_LAST(REQ_LAST), .REQ_READY(REQ_READY), .TX_DATA(TX_DATA),
    .TX_START(TX_START), .TX_BUSY(TX_BUSY), .GRANT_ID(GRANT_ID),
    .ERR_TIMEOUT(ERR_TIMEOUT), .IDLE(IDLE)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // stage: 0 = free, 1 = byte handed over awaiting busy, 2 = transmitting
  int         m_stage = 0, m_ptr = 0, m_age = 0, m_cyc = 0, m_w = 0, m_w2 = 0;
  bit         m_lock = 0;
  int         m_lock_id = 0;
  logic [7:0] e_data = 0;
  bit         e_start = 0, e_err = 0;
  int         e_grant = 0;
  int         acc_b[$], acc_g[$], acc_c[$];
  logic [N-1:0] exp_ready;

  function automatic int pick(logic [N-1:0] v, int p, bit lk, int lid);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (v[i] && (!lk || i == lid)) return i;
    end
    return -1;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_stage = 0; m_ptr = 0; m_age = 0; m_lock = 0; m_lock_id = 0;
      e_data = 0; e_start = 0; e_err = 0; e_grant = 0;
    end else begin
      m_cyc++;
      e_err = 0;
      if (m_stage == 0) begin
        m_w = pick(REQ_VALID, m_ptr, m_lock, m_lock_id);
        if (m_w >= 0) begin
          e_data  = REQ_DATA[8*m_w +: 8];
          e_start = 1;
          e_grant = m_w;
          m_ptr   = (m_w + 1) % N;
          m_stage = 1;
          m_age   = 0;
          acc_b.push_back(int'(REQ_DATA[8*m_w +: 8]));
          acc_g.push_back(m_w);
          acc_c.push_back(m_cyc);
`ifdef UART_ARB_LOCK_EN
          m_lock    = !REQ_LAST[m_w];
          m_lock_id = m_w;
`endif
        end
      end else if ((m_stage == 1 && TX_BUSY) || (m_stage == 2 && !TX_BUSY)) begin
        m_stage = (m_stage == 1) ? 2 : 0;
        e_start = 0;
        m_age   = 0;
      end else begin
        m_age++;
        if (m_age == TO) begin
          m_stage = 0; e_start = 0; e_err = 1; m_lock = 0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    exp_ready = '0;
    if (RST_N && m_stage == 0) begin
      m_w2 = pick(REQ_VALID, m_ptr, m_lock, m_lock_id);
      if (m_w2 >= 0) exp_ready[m_w2] = 1'b1;
    end
    chk("cyc_ready", REQ_READY, exp_ready);
    chk("cyc_tx_start", TX_START, e_start);
    chk("cyc_tx_data", TX_DATA, e_data);
    chk("cyc_grant", GRANT_ID, e_grant);
    chk("cyc_err", ERR_TIMEOUT, e_err);
    chk("cyc_idle", IDLE, (m_stage == 0));
  end

  // ---------------- transmitter emulation ----------------
  bit tx_en = 1;
  int bdly = 2, blen = 2, em_ph = 0, em_cnt = 0;

  initial begin
    forever begin
      @(posedge CLK); #2;
      if (em_ph == 0 && tx_en && TX_START) begin em_ph = 1; em_cnt = 0; end
      if (em_ph == 1) begin
        if (em_cnt >= bdly) begin TX_BUSY = 1; em_ph = 2; em_cnt = 0; end
        else em_cnt++;
      end else if (em_ph == 2) begin
        em_cnt++;
        if (em_cnt >= blen) begin TX_BUSY = 0; em_ph = 0; end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK); #2;
  endtask

  task automatic wait_acc(input int n);
    int b = 0;
    while (acc_b.size() < n && b < 200) begin tick(); b++; end
    chk("accept_seen", (acc_b.size() >= n), 1);
  endtask

  task automatic wait_idle();
    int b = 0;
    while (!IDLE && b < 200) begin tick(); b++; end
    chk("idle_reached", IDLE, 1);
  endtask

  task automatic send(input logic [N-1:0] m);
    int t;
    t = acc_b.size() + 1;
    REQ_VALID = m;
    wait_acc(t);
    REQ_VALID = '0;
    wait_idle();
  endtask

  initial begin
    int n, base;
    int exp_rr_b[5] = '{'hA0, 'hA1, 'hA2, 'hA3, 'hA0};
    int exp_rr_g[5] = '{0, 1, 2, 3, 0};
`ifdef UART_ARB_LOCK_EN
    int exp_lk[3] = '{'h10, 'h11, 'hA0};
`else
    int exp_lk[3] = '{'h10, 'hA0, 'h11};
`endif

    // reset and single requester
    REQ_DATA = {8'hA3, 8'hA2, 8'hA1, 8'h55};
    #1 RST_N = 0;
    #1 REQ_VALID = 4'b0001;
    #11;
    chk("rst_ready", REQ_READY, 4'b0000);
    chk("rst_tx_start", TX_START, 0);
    chk("rst_tx_data", TX_DATA, 8'h00);
    chk("rst_idle", IDLE, 1);
    chk("rst_grant", GRANT_ID, 0);
    chk("rst_err", ERR_TIMEOUT, 0);
    tick();
    RST_N = 1;
    #1 chk("t1_ready", REQ_READY, 4'b0001);
    tick();
    chk("t1_start", TX_START, 1);
    chk("t1_data", TX_DATA, 8'h55);
    chk("t1_grant", GRANT_ID, 0);
    chk("t1_ready_off", REQ_READY, 4'b0000);
    REQ_VALID = '0;
    n = 0;
    while (TX_START && n < 50) begin tick(); n++; end
    chk("t1_start_len", n, 3);
    wait_idle();
    chk("t1_log_byte", acc_b[0], 'h55);

    // round robin, back-to-back with minimum spacing
    REQ_DATA = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    send(4'b1000);
    chk("pre_rr_grant", acc_g[acc_g.size()-1], 3);
    bdly = 0; blen = 1;
    base = acc_b.size();
    REQ_VALID = '1;
    wait_acc(base + 5);
    REQ_VALID = '0;
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      chk("rr_byte", acc_b[base+i], exp_rr_b[i]);
      chk("rr_grant", acc_g[base+i], exp_rr_g[i]);
    end
    chk("rr_spacing", acc_c[base+1] - acc_c[base], 3);

    // wrap-around
    send(4'b0100);
    REQ_VALID = 4'b0100;
    #1 chk("wrap_ready", REQ_READY, 4'b0100);
    base = acc_b.size();
    wait_acc(base + 1);
    REQ_VALID = '0;
    wait_idle();
    chk("wrap_grant", acc_g[base], 2);
    REQ_VALID = 4'b1001;
    #1 chk("wrap_ptr3_ready", REQ_READY, 4'b1000);
    wait_acc(base + 2);
    REQ_VALID = '0;
    wait_idle();

    // watchdog with BUSY stuck low
    tx_en = 0;
    REQ_VALID = 4'b0010;
    wait_acc(acc_b.size() + 1);
    REQ_VALID = '0;
    n = 0;
    while (n < 100) begin
      @(posedge CLK); #1;
      n++;
      if (ERR_TIMEOUT) break;
    end
    chk("to_cycles", n, 16);
    chk("to_start", TX_START, 0);
    chk("to_idle", IDLE, 1);
    @(posedge CLK); #1;
    chk("to_pulse_len", ERR_TIMEOUT, 0);
    tx_en = 1;
    #1;
    send(4'b1001);
    chk("to_next_grant", acc_g[acc_g.size()-1], 3);
    send(4'b0001);

    // message lock (order depends on the build option)
    REQ_LAST = 4'b0001;
    REQ_DATA[15:8] = 8'h10;
    base = acc_b.size();
    REQ_VALID = 4'b0011;
    for (int k = 1; k <= 3; k++) begin
      wait_acc(base + k);
      if (acc_g[acc_g.size()-1] == 0) REQ_VALID[0] = 1'b0;
      else if (acc_b[acc_b.size()-1] == 'h10) begin
        REQ_DATA[15:8] = 8'h11;
        REQ_LAST[1] = 1'b1;
      end else REQ_VALID[1] = 1'b0;
    end
    REQ_VALID = '0;
    wait_idle();
    for (int i = 0; i < 3; i++) chk("lock_order", acc_b[base+i], exp_lk[i]);

    // reset during WAIT
    REQ_LAST = '1;
    bdly = 0; blen = 10;
    REQ_VALID = 4'b0100;
    wait_acc(acc_b.size() + 1);
    REQ_VALID = '0;
    tick();
    chk("wait_idle_low", IDLE, 0);
    chk("wait_start_low", TX_START, 0);
    REQ_VALID = '1;
    RST_N = 0;
    #1;
    chk("mid_rst_start", TX_START, 0);
    chk("mid_rst_err", ERR_TIMEOUT, 0);
    chk("mid_rst_ready", REQ_READY, 4'b0000);
    chk("mid_rst_idle", IDLE, 1);
    chk("mid_rst_grant", GRANT_ID, 0);
    tick(); tick();
    RST_N = 1;
    #1 chk("post_rst_ready", REQ_READY, 4'b0001);
    base = acc_b.size();
    wait_acc(base + 1);
    REQ_VALID = '0;
    chk("post_rst_grant", acc_g[base], 0);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
